// File: rtl/down_counter_timer.sv
// Loadable synchronous down counter with start/done handshake and optional
// auto-reload. Counts from a programmed value to zero; borrow pulses on expiry.
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             stop,
  input  logic             done_ack,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             borrow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_val;

  // Control FSM and datapath; priority is rst > stop > start > done_ack > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q          <= '0;
      reload_val <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      borrow     <= 1'b0;
    end else begin
      borrow <= 1'b0;
      if (stop) begin
        // Abort: q keeps its value and a coincident final decrement is dropped.
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start) begin
        q          <= load_val;
        reload_val <= load_val;
        if (load_val != '0) begin
          state <= RUN;
          busy  <= 1'b1;
          done  <= 1'b0;
        end else begin
          // Zero-length count expires immediately.
          state  <= EXPIRED;
          busy   <= 1'b0;
          done   <= 1'b1;
          borrow <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (en) begin
              if (q > WIDTH'(1)) begin
                q <= q - WIDTH'(1);
              end else if (auto_reload) begin
                q      <= reload_val;
                borrow <= 1'b1;
              end else begin
                q      <= '0;
                state  <= EXPIRED;
                busy   <= 1'b0;
                done   <= 1'b1;
                borrow <= 1'b1;
              end
            end
          end
          EXPIRED: begin
            if (done_ack) begin
              state <= IDLE;
              done  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed testbench for down_counter_timer (WIDTH=4 and WIDTH=8 instances).
module tb_down_counter_timer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] load_val;
  logic       en;
  logic       auto_reload;
  logic       stop;
  logic       done_ack;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       borrow;

  logic       start8;
  logic [7:0] load_val8;
  logic [7:0] q8;
  logic       busy8;
  logic       done8;
  logic       borrow8;

  int checks;
  int errors;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .en(en),
    .auto_reload(auto_reload), .stop(stop), .done_ack(done_ack),
    .q(q), .busy(busy), .done(done), .borrow(borrow)
  );

  down_counter_timer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .load_val(load_val8), .en(en),
    .auto_reload(auto_reload), .stop(stop), .done_ack(done_ack),
    .q(q8), .busy(busy8), .done(done8), .borrow(borrow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] eq, input logic eb,
                      input logic ed, input logic ebr);
    chk({tag, ".q"},      32'(q),      32'(eq));
    chk({tag, ".busy"},   32'(busy),   32'(eb));
    chk({tag, ".done"},   32'(done),   32'(ed));
    chk({tag, ".borrow"}, 32'(borrow), 32'(ebr));
  endtask

  initial begin
    logic [3:0] ar_q [8];
    logic       ar_b [8];
    logic [3:0] tg_q [8];
    logic       tg_d [8];
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
    stop = 1'b0; done_ack = 1'b0; start8 = 1'b0; load_val8 = '0;
    step();
    step();
    chk4("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset8.q", 32'(q8), 32'd0);
    rst = 1'b0;

    // One-shot count from 5
    load_val = 4'd5; start = 1'b1; en = 1'b1;
    step();
    chk4("os_load", 4'd5, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      step();
      chk4("os_count", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    step();
    chk4("os_expire", 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    chk4("os_hold", 4'd0, 1'b0, 1'b1, 1'b0);
    done_ack = 1'b1;
    step();
    chk4("os_ack", 4'd0, 1'b0, 1'b0, 1'b0);
    done_ack = 1'b0;

    // Auto-reload period 3
    ar_q = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1};
    ar_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    load_val = 4'd3; start = 1'b1; auto_reload = 1'b1;
    step();
    chk4("ar_load", 4'd3, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk4("ar_count", ar_q[i], 1'b1, 1'b0, ar_b[i]);
    end
    stop = 1'b1;
    step();
    chk4("ar_stop", 4'd1, 1'b0, 1'b0, 1'b0);
    stop = 1'b0; auto_reload = 1'b0;

    // Gated enable: only en=1 cycles decrement
    tg_q = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
    tg_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    load_val = 4'd4; start = 1'b1; en = 1'b1;
    step();
    chk4("en_load", 4'd4, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 0);
      step();
      chk4("en_gate", tg_q[i], !tg_d[i], tg_d[i], (i == 6));
    end
    en = 1'b1; done_ack = 1'b1;
    step();
    chk4("en_ack", 4'd0, 1'b0, 1'b0, 1'b0);
    done_ack = 1'b0;

    // Zero-length load
    load_val = 4'd0; start = 1'b1;
    step();
    chk4("zero_load", 4'd0, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    step();
    chk4("zero_hold", 4'd0, 1'b0, 1'b1, 1'b0);

    // start beats done_ack in EXPIRED
    load_val = 4'd15; start = 1'b1; done_ack = 1'b1;
    step();
    chk4("start_vs_ack", 4'd15, 1'b1, 1'b0, 1'b0);
    start = 1'b0; done_ack = 1'b0;
    step();
    chk4("full_scale", 4'd14, 1'b1, 1'b0, 1'b0);

    // Restart from RUN then stop at 6; IDLE ignores en
    load_val = 4'd6; start = 1'b1;
    step();
    chk4("restart", 4'd6, 1'b1, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b1;
    step();
    chk4("stop6", 4'd6, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    step();
    chk4("idle_hold", 4'd6, 1'b0, 1'b0, 1'b0);

    // Stop coincident with final decrement suppresses borrow
    load_val = 4'd1; start = 1'b1;
    step();
    chk4("last_load", 4'd1, 1'b1, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b1;
    step();
    chk4("stop_last", 4'd1, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Reset mid-count
    load_val = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk4("pre_rst", 4'd2, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk4("mid_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // auto_reload sampled at expiry
    load_val = 4'd2; start = 1'b1; auto_reload = 1'b1;
    step();
    start = 1'b0; auto_reload = 1'b0;
    step();
    chk4("ar_mid1", 4'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk4("ar_mid_exp", 4'd0, 1'b0, 1'b1, 1'b1);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;

    // WIDTH=8 full scale: 255 enabled cycles to expiry
    load_val8 = 8'd255; start8 = 1'b1; en = 1'b1;
    step();
    chk("w8_load.q", 32'(q8), 32'd255);
    chk("w8_load.busy", 32'(busy8), 32'd1);
    start8 = 1'b0;
    for (int k = 1; k <= 254; k++) begin
      step();
      chk("w8_count.q", 32'(q8), 32'(255 - k));
    end
    step();
    chk("w8_exp.q", 32'(q8), 32'd0);
    chk("w8_exp.done", 32'(done8), 32'd1);
    chk("w8_exp.borrow", 32'(borrow8), 32'd1);
    chk("w8_exp.busy", 32'(busy8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
